uc_fsm_multicycle: RTL and testbench

- Parametrised successor to the multicycle MIPS control unit.
- Implements the full IF/ID/EX/MA/WB sequence for the supported R/I/J subset, including loads/stores with a memory-ready handshake, bne, jal and jr.
- Adds an illegal-instruction trap.
- Sits between the instruction register (Op/Funct) and the multicycle datapath muxes, register file and memory.

---
 rtl/uc_fsm_multicycle_if.sv | 43 ++++
 rtl/uc_fsm_multicycle.sv | 242 ++++++++++++++++++++++++
 tb/tb_uc_fsm_multicycle.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uc_fsm_multicycle_if.sv
// Control bundle between the instruction register / datapath and the multicycle controller.
// master = controller (consumes Op/Funct/MemReady, drives strobes); slave = datapath side.
interface uc_fsm_multicycle_if #(
  parameter int ALUC_W = 3
) ();
  logic [5:0]        Op;
  logic [5:0]        Funct;
  logic              MemReady;

  logic              PCWrite;
  logic              BranchEq;
  logic              BranchNeq;
  logic              IorD;
  logic              MemWrite;
  logic              MemRead;
  logic              IRWrite;
  logic              RegDst;
  logic              MemtoReg;
  logic              RegWrite;
  logic              ALUSrcA;
  logic              PCSrc;
  logic              Jen;
  logic              SignZero;
  logic              Link;
  logic [1:0]        ALUSrcB;
  logic [ALUC_W-1:0] ALUControl;
  logic              Illegal;
  logic [2:0]        State;

  modport master (
    input  Op, Funct, MemReady,
    output PCWrite, BranchEq, BranchNeq, IorD, MemWrite, MemRead, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, Jen, SignZero, Link,
           ALUSrcB, ALUControl, Illegal, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  PCWrite, BranchEq, BranchNeq, IorD, MemWrite, MemRead, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, Jen, SignZero, Link,
           ALUSrcB, ALUControl, Illegal, State
  );
endinterface

// File: rtl/uc_fsm_multicycle.sv
// Multicycle MIPS control FSM (IF/ID/EX/MA/WB + illegal-instruction TRAP); outputs are combinational
// from state and IR fields. CPI 2..5; IF and MA stall while MemReady is low (when USE_MEM_READY=1).
module uc_fsm_multicycle #(
  parameter int ALUC_W        = 3,
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit TRAP_HALT     = 1'b1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  uc_fsm_multicycle_if.master    bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t r_state;
  state_t w_next;

  logic       w_mem_rdy;
  logic       w_is_r;
  logic       w_is_jr;
  logic       w_op_ok;
  logic       w_funct_ok;
  logic       w_legal;
  logic [2:0] w_alu_r;

  logic       w_pcwrite, w_brancheq, w_branchneq, w_iord, w_memwrite, w_memread;
  logic       w_irwrite, w_regdst, w_memtoreg, w_regwrite, w_alusrca, w_pcsrc;
  logic       w_jen, w_signzero, w_link, w_illegal;
  logic [1:0] w_alusrcb;
  logic [2:0] w_aluc;

  assign w_mem_rdy = USE_MEM_READY ? bus.MemReady : 1'b1;
  assign w_is_r    = (bus.Op == OP_R);
  assign w_is_jr   = w_is_r && (bus.Funct == F_JR);

  // R-type function decode; jr routes rs through OR with rt=$0.
  always_comb begin
    w_alu_r    = ALU_AND;
    w_funct_ok = 1'b1;
    case (bus.Funct)
      F_ADD, F_ADDU: w_alu_r = ALU_ADD;
      F_SUB, F_SUBU: w_alu_r = ALU_SUB;
      F_AND:         w_alu_r = ALU_AND;
      F_OR:          w_alu_r = ALU_OR;
      F_NOR:         w_alu_r = ALU_NOR;
      F_SLT:         w_alu_r = ALU_SLT;
      F_JR:          w_alu_r = ALU_OR;
      default:       w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: w_op_ok = 1'b1;
      default:                       w_op_ok = 1'b0;
    endcase
  end

  assign w_legal = w_op_ok && (!w_is_r || w_funct_ok);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = S_TRAP;
    w_pcwrite   = 1'b0;
    w_brancheq  = 1'b0;
    w_branchneq = 1'b0;
    w_iord      = 1'b0;
    w_memwrite  = 1'b0;
    w_memread   = 1'b0;
    w_irwrite   = 1'b0;
    w_regdst    = 1'b0;
    w_memtoreg  = 1'b0;
    w_regwrite  = 1'b0;
    w_alusrca   = 1'b0;
    w_pcsrc     = 1'b0;
    w_jen       = 1'b0;
    w_signzero  = 1'b0;
    w_link      = 1'b0;
    w_illegal   = 1'b0;
    w_alusrcb   = 2'b00;
    w_aluc      = ALU_AND;

    case (r_state)
      S_IF: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_aluc    = ALU_ADD;
        w_irwrite = w_mem_rdy;
        w_pcwrite = w_mem_rdy;
        w_next    = w_mem_rdy ? S_ID : S_IF;
      end

      S_ID: begin
        // Branch target precomputed into ALUOut regardless of opcode.
        w_alusrcb = 2'b11;
        w_aluc    = ALU_ADD;
        if (bus.Op == OP_J) begin
          w_pcwrite = 1'b1;
          w_jen     = 1'b1;
          w_next    = S_IF;
        end else if (bus.Op == OP_JAL) begin
          w_pcwrite  = 1'b1;
          w_jen      = 1'b1;
          w_link     = 1'b1;
          w_regwrite = 1'b1;
          w_next     = S_IF;
        end else if (!w_legal) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_EX;
        end
      end

      S_EX: begin
        w_alusrca = 1'b1;
        if (w_is_r) begin
          w_alusrcb = 2'b00;
          w_aluc    = w_alu_r;
          if (w_is_jr) begin
            w_pcwrite = 1'b1;
            w_next    = S_IF;
          end else begin
            w_next = w_funct_ok ? S_WB : S_TRAP;
          end
        end else begin
          case (bus.Op)
            OP_ADDI: begin w_alusrcb = 2'b10; w_aluc = ALU_ADD; w_next = S_WB; end
            OP_SLTI: begin w_alusrcb = 2'b10; w_aluc = ALU_SLT; w_next = S_WB; end
            OP_ANDI: begin w_alusrcb = 2'b10; w_aluc = ALU_AND; w_signzero = 1'b1; w_next = S_WB; end
            OP_ORI:  begin w_alusrcb = 2'b10; w_aluc = ALU_OR;  w_signzero = 1'b1; w_next = S_WB; end
            OP_LW, OP_SW: begin
              w_alusrcb = 2'b10;
              w_aluc    = ALU_ADD;
              w_next    = S_MA;
            end
            OP_BEQ, OP_BNE: begin
              w_alusrcb   = 2'b00;
              w_aluc      = ALU_SUB;
              w_pcsrc     = 1'b1;
              w_brancheq  = (bus.Op == OP_BEQ);
              w_branchneq = (bus.Op == OP_BNE);
              w_next      = S_IF;
            end
            default: w_next = S_TRAP;
          endcase
        end
      end

      S_MA: begin
        w_iord = 1'b1;
        if (bus.Op == OP_LW) begin
          w_memread = 1'b1;
          w_next    = w_mem_rdy ? S_WB : S_MA;
        end else if (bus.Op == OP_SW) begin
          w_memwrite = 1'b1;
          w_next     = w_mem_rdy ? S_IF : S_MA;
        end else begin
          w_next = S_TRAP;
        end
      end

      S_WB: begin
        w_regwrite = 1'b1;
        w_regdst   = w_is_r;
        w_memtoreg = (bus.Op == OP_LW);
        w_next     = S_IF;
      end

      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = TRAP_HALT ? S_TRAP : S_IF;
      end

      default: w_next = S_TRAP;
    endcase
  end

  assign bus.PCWrite    = w_pcwrite;
  assign bus.BranchEq   = w_brancheq;
  assign bus.BranchNeq  = w_branchneq;
  assign bus.IorD       = w_iord;
  assign bus.MemWrite   = w_memwrite;
  assign bus.MemRead    = w_memread;
  assign bus.IRWrite    = w_irwrite;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.RegWrite   = w_regwrite;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.Jen        = w_jen;
  assign bus.SignZero   = w_signzero;
  assign bus.Link       = w_link;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = ALUC_W'(w_aluc);
  assign bus.Illegal    = w_illegal;
  assign bus.State      = r_state;

endmodule

// File: tb/tb_uc_fsm_multicycle.sv
// Scoreboard bench for uc_fsm_multicycle: directed per-cycle vectors push expected state/controls,
// a negedge monitor pops and compares. dut0 = default params, dut1 = no MemReady wait, 1-cycle TRAP.
module tb_uc_fsm_multicycle;

  typedef struct packed {
    logic PCWrite, BranchEq, BranchNeq, IorD, MemWrite, MemRead, IRWrite, RegDst;
    logic MemtoReg, RegWrite, ALUSrcA, PCSrc, Jen, SignZero, Link;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic Illegal;
  } ctrl_t;

  typedef struct {
    logic       sel;
    logic [2:0] state;
    ctrl_t      ctrl;
    int         idx;
  } exp_t;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MA = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

  localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] SLTI = 6'h0A, ORI = 6'h0D, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;

  localparam ctrl_t C_IF_RDY  = '{PCWrite:1'b1, MemRead:1'b1, IRWrite:1'b1, ALUSrcB:2'b01, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_IF_WAIT = '{MemRead:1'b1, ALUSrcB:2'b01, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_ID      = '{ALUSrcB:2'b11, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_ID_J    = '{PCWrite:1'b1, Jen:1'b1, ALUSrcB:2'b11, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_ID_JAL  = '{PCWrite:1'b1, Jen:1'b1, Link:1'b1, RegWrite:1'b1, ALUSrcB:2'b11, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_EX_ADD  = '{ALUSrcA:1'b1, ALUSrcB:2'b00, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_EX_SUB  = '{ALUSrcA:1'b1, ALUSrcB:2'b00, ALUControl:3'b110, default:'0};
  localparam ctrl_t C_EX_JR   = '{PCWrite:1'b1, ALUSrcA:1'b1, ALUSrcB:2'b00, ALUControl:3'b001, default:'0};
  localparam ctrl_t C_EX_ORI  = '{ALUSrcA:1'b1, SignZero:1'b1, ALUSrcB:2'b10, ALUControl:3'b001, default:'0};
  localparam ctrl_t C_EX_SLTI = '{ALUSrcA:1'b1, ALUSrcB:2'b10, ALUControl:3'b111, default:'0};
  localparam ctrl_t C_EX_MEM  = '{ALUSrcA:1'b1, ALUSrcB:2'b10, ALUControl:3'b010, default:'0};
  localparam ctrl_t C_EX_BNE  = '{BranchNeq:1'b1, PCSrc:1'b1, ALUSrcA:1'b1, ALUSrcB:2'b00, ALUControl:3'b110, default:'0};
  localparam ctrl_t C_EX_BEQ  = '{BranchEq:1'b1, PCSrc:1'b1, ALUSrcA:1'b1, ALUSrcB:2'b00, ALUControl:3'b110, default:'0};
  localparam ctrl_t C_MA_LW   = '{IorD:1'b1, MemRead:1'b1, default:'0};
  localparam ctrl_t C_MA_SW   = '{IorD:1'b1, MemWrite:1'b1, default:'0};
  localparam ctrl_t C_WB_R    = '{RegWrite:1'b1, RegDst:1'b1, default:'0};
  localparam ctrl_t C_WB_I    = '{RegWrite:1'b1, default:'0};
  localparam ctrl_t C_WB_LW   = '{RegWrite:1'b1, MemtoReg:1'b1, default:'0};
  localparam ctrl_t C_TRAP    = '{Illegal:1'b1, default:'0};

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       rdy = 1'b0;

  always #5 CLK = ~CLK;

  uc_fsm_multicycle_if #(.ALUC_W(3)) bus0 ();
  uc_fsm_multicycle_if #(.ALUC_W(3)) bus1 ();

  assign bus0.Op = op;  assign bus0.Funct = funct;  assign bus0.MemReady = rdy;
  assign bus1.Op = op;  assign bus1.Funct = funct;  assign bus1.MemReady = rdy;

  uc_fsm_multicycle #(.ALUC_W(3), .USE_MEM_READY(1'b1), .TRAP_HALT(1'b1)) dut0 (
    .CLK (CLK), .CLR (CLR), .bus (bus0.master)
  );
  uc_fsm_multicycle #(.ALUC_W(3), .USE_MEM_READY(1'b0), .TRAP_HALT(1'b0)) dut1 (
    .CLK (CLK), .CLR (CLR), .bus (bus1.master)
  );

  ctrl_t g0, g1;
  assign g0 = {bus0.PCWrite, bus0.BranchEq, bus0.BranchNeq, bus0.IorD, bus0.MemWrite, bus0.MemRead,
               bus0.IRWrite, bus0.RegDst, bus0.MemtoReg, bus0.RegWrite, bus0.ALUSrcA, bus0.PCSrc,
               bus0.Jen, bus0.SignZero, bus0.Link, bus0.ALUSrcB, bus0.ALUControl, bus0.Illegal};
  assign g1 = {bus1.PCWrite, bus1.BranchEq, bus1.BranchNeq, bus1.IorD, bus1.MemWrite, bus1.MemRead,
               bus1.IRWrite, bus1.RegDst, bus1.MemtoReg, bus1.RegWrite, bus1.ALUSrcA, bus1.PCSrc,
               bus1.Jen, bus1.SignZero, bus1.Link, bus1.ALUSrcB, bus1.ALUControl, bus1.Illegal};

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    n_vec  = 0;

  // Drive one cycle's inputs just after the edge and queue the outputs expected for that cycle.
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic r, input logic c,
                      input logic chk, input logic s, input logic [2:0] st, input ctrl_t ct);
    exp_t e;
    @(posedge CLK);
    #1;
    op = o; funct = f; rdy = r; CLR = c;
    if (chk) begin
      e.sel = s; e.state = st; e.ctrl = ct; e.idx = n_vec;
      q.push_back(e);
      n_vec++;
    end
  endtask

  task automatic c0(input logic [5:0] o, input logic [5:0] f, input logic r, input logic c,
                    input logic [2:0] st, input ctrl_t ct);
    step(o, f, r, c, 1'b1, 1'b0, st, ct);
  endtask

  task automatic c1(input logic [5:0] o, input logic [5:0] f, input logic r, input logic c,
                    input logic [2:0] st, input ctrl_t ct);
    step(o, f, r, c, 1'b1, 1'b1, st, ct);
  endtask

  exp_t       m_e;
  logic [2:0] m_gs;
  ctrl_t      m_gc;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      m_e  = q.pop_front();
      m_gs = m_e.sel ? bus1.State : bus0.State;
      m_gc = m_e.sel ? g1 : g0;
      checks++;
      if (m_gs !== m_e.state) begin
        errors++;
        $display("FAIL state vec%0d dut%0d: got %0d want %0d", m_e.idx, m_e.sel, m_gs, m_e.state);
      end
      checks++;
      if (m_gc !== m_e.ctrl) begin
        errors++;
        $display("FAIL ctrl vec%0d dut%0d state%0d: got %h want %h", m_e.idx, m_e.sel, m_e.state, m_gc, m_e.ctrl);
      end
    end
  end

  initial begin
    // add
    c0(R, 6'h20, 1, 1, S_IF, C_IF_RDY);
    c0(R, 6'h20, 1, 1, S_ID, C_ID);
    c0(R, 6'h20, 1, 1, S_EX, C_EX_ADD);
    c0(R, 6'h20, 1, 1, S_WB, C_WB_R);
    // lw with one IF wait and two MA waits
    c0(LW, 6'h00, 0, 1, S_IF, C_IF_WAIT);
    c0(LW, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(LW, 6'h00, 1, 1, S_ID, C_ID);
    c0(LW, 6'h00, 1, 1, S_EX, C_EX_MEM);
    c0(LW, 6'h00, 0, 1, S_MA, C_MA_LW);
    c0(LW, 6'h00, 0, 1, S_MA, C_MA_LW);
    c0(LW, 6'h00, 1, 1, S_MA, C_MA_LW);
    c0(LW, 6'h00, 1, 1, S_WB, C_WB_LW);
    // sw with one MA wait
    c0(SW, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(SW, 6'h00, 1, 1, S_ID, C_ID);
    c0(SW, 6'h00, 1, 1, S_EX, C_EX_MEM);
    c0(SW, 6'h00, 0, 1, S_MA, C_MA_SW);
    c0(SW, 6'h00, 1, 1, S_MA, C_MA_SW);
    // bne, beq
    c0(BNE, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(BNE, 6'h00, 1, 1, S_ID, C_ID);
    c0(BNE, 6'h00, 1, 1, S_EX, C_EX_BNE);
    c0(BEQ, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(BEQ, 6'h00, 1, 1, S_ID, C_ID);
    c0(BEQ, 6'h00, 1, 1, S_EX, C_EX_BEQ);
    // ori, slti, sub
    c0(ORI, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(ORI, 6'h00, 1, 1, S_ID, C_ID);
    c0(ORI, 6'h00, 1, 1, S_EX, C_EX_ORI);
    c0(ORI, 6'h00, 1, 1, S_WB, C_WB_I);
    c0(SLTI, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(SLTI, 6'h00, 1, 1, S_ID, C_ID);
    c0(SLTI, 6'h00, 1, 1, S_EX, C_EX_SLTI);
    c0(SLTI, 6'h00, 1, 1, S_WB, C_WB_I);
    c0(R, 6'h22, 1, 1, S_IF, C_IF_RDY);
    c0(R, 6'h22, 1, 1, S_ID, C_ID);
    c0(R, 6'h22, 1, 1, S_EX, C_EX_SUB);
    c0(R, 6'h22, 1, 1, S_WB, C_WB_R);
    // jal, j, jr
    c0(JAL, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(JAL, 6'h00, 1, 1, S_ID, C_ID_JAL);
    c0(J, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(J, 6'h00, 1, 1, S_ID, C_ID_J);
    c0(R, 6'h08, 1, 1, S_IF, C_IF_RDY);
    c0(R, 6'h08, 1, 1, S_ID, C_ID);
    c0(R, 6'h08, 1, 1, S_EX, C_EX_JR);
    // unsupported funct traps and halts until reset
    c0(R, 6'h01, 1, 1, S_IF, C_IF_RDY);
    c0(R, 6'h01, 1, 1, S_ID, C_ID);
    c0(R, 6'h01, 1, 1, S_TRAP, C_TRAP);
    c0(R, 6'h01, 1, 1, S_TRAP, C_TRAP);
    c0(R, 6'h01, 1, 0, S_TRAP, C_TRAP);
    // unsupported opcode
    c0(BAD, 6'h00, 0, 1, S_IF, C_IF_WAIT);
    c0(BAD, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(BAD, 6'h00, 1, 1, S_ID, C_ID);
    c0(BAD, 6'h00, 1, 1, S_TRAP, C_TRAP);
    c0(BAD, 6'h00, 1, 0, S_TRAP, C_TRAP);
    // reset while sw waits in MA
    c0(SW, 6'h00, 1, 1, S_IF, C_IF_RDY);
    c0(SW, 6'h00, 1, 1, S_ID, C_ID);
    c0(SW, 6'h00, 1, 1, S_EX, C_EX_MEM);
    c0(SW, 6'h00, 0, 0, S_MA, C_MA_SW);
    c0(SW, 6'h00, 0, 1, S_IF, C_IF_WAIT);

    // dut1: MemReady ignored, TRAP lasts one cycle
    step(BAD, 6'h00, 0, 0, 1'b0, 1'b1, S_IF, C_IF_RDY);
    c1(BAD, 6'h00, 0, 1, S_IF, C_IF_RDY);
    c1(BAD, 6'h00, 0, 1, S_ID, C_ID);
    c1(BAD, 6'h00, 0, 1, S_TRAP, C_TRAP);
    c1(LW, 6'h00, 0, 1, S_IF, C_IF_RDY);
    c1(LW, 6'h00, 0, 1, S_ID, C_ID);
    c1(LW, 6'h00, 0, 1, S_EX, C_EX_MEM);
    c1(LW, 6'h00, 0, 1, S_MA, C_MA_LW);
    c1(LW, 6'h00, 0, 1, S_WB, C_WB_LW);
    c1(LW, 6'h00, 0, 1, S_IF, C_IF_RDY);

    repeat (3) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
